weight_sequencer: RTL and testbench
===================================

# weight_sequencer

Upstream issue stage for the weight path: on a start pulse it walks every output-depth pair and input-depth chunk of the current layer and drives one (od1, id) request per cycle into the weight controller's main-controller inputs. It honours a ready/stall signal from the PE array side, waits for the weight controller's 2-cycle pipeline to drain, then pulses done. Layer geometry is latched at start, and layers whose weight address space exceeds 8 bits are rejected.

## Interface
- DRAIN_CYCLES, default 2: weight controller latency (SRAM read plus output register) to wait after the last issue.
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset.
- start_i  input  1  single-cycle layer start request.
- total_od_i  input  8  layer output depth, latched at start.
- total_id_i  input  4  layer input-depth chunk count, latched at start.
- pe_ready_i  input  1  1 = downstream can accept a request this cycle.
- weight_od1_o  output  8  even output-depth index of the current pair.
- weight_id_o  output  4  input-depth chunk index.
- weight_main_valid_o  output  1  request valid this cycle.
- weight_od2_valid_o  output  1  1 = od1+1 < total_od, so the second package is real.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse at end of layer.
- err_o  output  1  one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start_i=1 latches total_od and total_id.
  - If total_od*total_id > 256 (16-bit product compare): pulse err_o next cycle and stay in IDLE.
  - Else if total_od==0 or total_id==0: go to DONE with no issues.
  - Else: clear counters (od1=0, id=0) and go to ISSUE.
- ISSUE:
  - weight_main_valid_o = pe_ready_i (combinational); od1/id outputs are the counter registers.
  - On each valid cycle, id increments. When id reaches total_id-1, id wraps to 0 and od1 += 2.
  - Ordering: od outer, id inner, so the PE array accumulates all chunks of one od pair consecutively.
  - The issue after which od1+2 >= total_od and id==total_id-1 is the last; move to DRAIN with drain counter = DRAIN_CYCLES.
  - pe_ready_i=0 holds all counters and outputs stable with valid low.
- DRAIN: count down each cycle; at 1, go to DONE. DRAIN_CYCLES==0 goes straight to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- weight_od2_valid_o = ((od1+1) < total_od_latched), computed in 9 bits. Low outside ISSUE.
- start_i outside IDLE is ignored; no queuing.
- Address fit: the largest address od1+1+total_od*(total_id-1) is <= 255 exactly when the product is <= 256.

## Timing
- Reset values: weight_od1_o=0, weight_id_o=0, weight_main_valid_o=0, weight_od2_valid_o=0, busy_o=0, done_o=0, err_o=0; state IDLE; latched config 0.
- Reset asserted mid-layer aborts immediately (asynchronous). No done is issued, and an in-flight request is dropped.
- With start at edge N: first valid in cycle N+1 when pe_ready_i=1.
- Issue count = ceil(total_od/2)*total_id valid cycles.
- done_o is high DRAIN_CYCLES+1 cycles after the last valid cycle: last valid in cycle L, done in cycle L+3 for the default.
- err_o is high in cycle N+1, and busy_o stays 0.
- Zero-size layer: busy in cycle N+1 (state DONE, done_o=1), IDLE in cycle N+2.

## Structure
- Shared package weight_pkg:
  - state enum (IDLE/ISSUE/DRAIN/DONE)
  - OD_W=8, ID_W=4, ADDR_SPACE=256 constants
  - DRAIN default
- Reused by weight_controller's address math.
- Single flat module. No sub-module is needed: the counter pair and FSM are tightly coupled.

## Test plan
- total_od=4, total_id=2, ready high → (od1,id) = (0,0),(0,1),(2,0),(2,1) on four consecutive cycles; od2_valid=1 throughout; done 3 cycles after the last valid; busy low the cycle after done.
- total_od=5, total_id=1 → od1 = 0,2,4; od2_valid = 1,1,0.
- total_od=4, total_id=2, pe_ready_i toggled 1,0,0,1,... → outputs frozen while ready=0; the same 4-request sequence appears, with no duplicates or skips.
- total_od=128, total_id=3 (384>256) → err_o pulse, no valid, busy 0. total_od=0 → done pulse in cycle N+1, no valid.
- total_od=128, total_id=2 (exactly 256) → accepted; last request od1=126, id=1, od2_valid=1.
- Reset driven low in the middle of ISSUE → all outputs 0 immediately. After release, a fresh start works. A start pulse during ISSUE leaves the sequence unchanged.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared weight-path definitions: sequencer FSM states, geometry widths and
// the address-space fit check, also used by the weight controller's address math.
package weight_pkg;

    localparam int OD_W          = 8;
    localparam int ID_W          = 4;
    localparam int ADDR_SPACE    = 256;
    localparam int DRAIN_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Largest address od1+1+od*(id-1) stays within 8 bits exactly when od*id <= 256.
    function automatic logic fits_addr_space(input logic [OD_W-1:0] od,
                                             input logic [ID_W-1:0] id);
        logic [15:0] prod;
        prod = 16'(od) * 16'(id);
        return prod <= 16'(ADDR_SPACE);
    endfunction

endpackage

// File: rtl/weight_sequencer.sv
// Weight request issue stage: walks od pairs (outer) and id chunks (inner) of a
// layer, one request per ready cycle, then waits for the controller to drain.
module weight_sequencer
    import weight_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [OD_W-1:0] total_od_i,
    input  logic [ID_W-1:0] total_id_i,
    input  logic            pe_ready_i,
    output logic [OD_W-1:0] weight_od1_o,
    output logic [ID_W-1:0] weight_id_o,
    output logic            weight_main_valid_o,
    output logic            weight_od2_valid_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    state_e          state_q, state_d;
    logic [OD_W-1:0] od1_q, od1_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [OD_W-1:0] tod_q, tod_d;
    logic [ID_W-1:0] tid_q, tid_d;
    logic [7:0]      drain_q, drain_d;
    logic            err_q, err_d;

    logic last_chunk;
    logic last_pair;

    assign last_chunk = (id_q == tid_q - 4'd1);
    // 9-bit compare so od1+2 cannot wrap when total_od is near 255.
    assign last_pair  = (({1'b0, od1_q} + 9'd2) >= {1'b0, tod_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            od1_q   <= '0;
            id_q    <= '0;
            tod_q   <= '0;
            tid_q   <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            od1_q   <= od1_d;
            id_q    <= id_d;
            tod_q   <= tod_d;
            tid_q   <= tid_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        od1_d   = od1_q;
        id_d    = id_q;
        tod_d   = tod_q;
        tid_d   = tid_q;
        drain_d = drain_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    tod_d = total_od_i;
                    tid_d = total_id_i;
                    od1_d = '0;
                    id_d  = '0;
                    if (!fits_addr_space(total_od_i, total_id_i))
                        err_d = 1'b1;
                    else if (total_od_i == '0 || total_id_i == '0)
                        state_d = DONE;
                    else
                        state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (pe_ready_i) begin
                    if (last_chunk) begin
                        id_d  = '0;
                        od1_d = od1_q + 8'd2;
                        if (last_pair) begin
                            drain_d = 8'(DRAIN_CYCLES);
                            state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                        end
                    end else begin
                        id_d = id_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q <= 8'd1)
                    state_d = DONE;
                else
                    drain_d = drain_q - 8'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign weight_od1_o        = od1_q;
    assign weight_id_o         = id_q;
    assign weight_main_valid_o = (state_q == ISSUE) && pe_ready_i;
    assign weight_od2_valid_o  = (state_q == ISSUE) && (({1'b0, od1_q} + 9'd1) < {1'b0, tod_q});
    assign busy_o              = (state_q != IDLE);
    assign done_o              = (state_q == DONE);
    assign err_o               = err_q;

endmodule

// File: tb/tb_weight_sequencer.sv
// Directed bench for weight_sequencer: expected requests are queued when a layer
// is started and popped by a negedge monitor as valid requests appear.
module tb_weight_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [7:0] total_od_i;
    logic [3:0] total_id_i;
    logic       pe_ready_i;
    logic [7:0] weight_od1_o;
    logic [3:0] weight_id_o;
    logic       weight_main_valid_o;
    logic       weight_od2_valid_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    weight_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .start_i             (start_i),
        .total_od_i          (total_od_i),
        .total_id_i          (total_id_i),
        .pe_ready_i          (pe_ready_i),
        .weight_od1_o        (weight_od1_o),
        .weight_id_o         (weight_id_o),
        .weight_main_valid_o (weight_main_valid_o),
        .weight_od2_valid_o  (weight_od2_valid_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_valid = 0;
    int first_valid = -1;
    int last_valid  = -1;
    logic [12:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int od1, input int id, input bit v);
        sb.push_back({8'(od1), 4'(id), v});
    endtask

    // Scoreboard monitor: every valid request must match the next queued one.
    always @(negedge clk) begin
        if (reset === 1'b1 && weight_main_valid_o === 1'b1) begin
            n_valid++;
            last_valid = cyc;
            if (first_valid < 0) first_valid = cyc;
            if (sb.size() == 0)
                chk("unexpected_valid", {19'd0, weight_od1_o, weight_id_o, weight_od2_valid_o}, 32'h1fff_0000);
            else
                chk("req", {19'd0, weight_od1_o, weight_id_o, weight_od2_valid_o}, {19'd0, sb.pop_front()});
        end
    end

    // mode 0: ready high; mode 1: ready 1,0,0,1 pattern; mode 2: extra start during ISSUE
    task automatic run_layer(input int od, input int id, input int mode, input string tag);
        int  scyc;
        bit  got;
        int  dcyc;
        bit [3:0] pat;
        pat = 4'b1001;
        @(posedge clk); #1;
        start_i = 1'b1; total_od_i = 8'(od); total_id_i = 4'(id); pe_ready_i = 1'b1;
        scyc = cyc; first_valid = -1;
        @(posedge clk); #1;
        start_i = 1'b0;
        got = 1'b0; dcyc = -1;
        for (int k = 0; k < 400; k++) begin
            if (mode == 1) pe_ready_i = pat[k % 4];
            if (mode == 2 && k == 1) begin
                start_i = 1'b1; total_od_i = 8'd2; total_id_i = 4'd1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            if (done_o === 1'b1) begin
                got = 1'b1; dcyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        pe_ready_i = 1'b1; start_i = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_first_valid"}, first_valid - scyc, 1);
        chk({tag, "_done_lat"}, dcyc - last_valid, 3);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {30'd0, done_o, busy_o}, 32'd0);
    endtask

    initial begin
        int nv;
        reset = 1'b0; start_i = 1'b0; total_od_i = '0; total_id_i = '0; pe_ready_i = 1'b0;
        #3;
        chk("reset_outs", {19'd0, weight_od1_o, weight_id_o, weight_main_valid_o},  32'd0);
        chk("reset_flags", {28'd0, weight_od2_valid_o, busy_o, done_o, err_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // 4x2, ready high
        push(0, 0, 1); push(0, 1, 1); push(2, 0, 1); push(2, 1, 1);
        run_layer(4, 2, 0, "l4x2");

        // 5x1: last pair has no second package
        push(0, 0, 1); push(2, 0, 1); push(4, 0, 0);
        run_layer(5, 1, 0, "l5x1");

        // 4x2 with stalls
        push(0, 0, 1); push(0, 1, 1); push(2, 0, 1); push(2, 1, 1);
        nv = n_valid;
        run_layer(4, 2, 1, "stall");
        chk("stall_count", n_valid - nv, 4);

        // 128x3 rejected
        nv = n_valid;
        @(posedge clk); #1;
        start_i = 1'b1; total_od_i = 8'd128; total_id_i = 4'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("err_pulse", {30'd0, err_o, busy_o}, 32'b10);
        @(negedge clk);
        chk("err_clear", {30'd0, err_o, busy_o}, 32'b00);
        repeat (3) @(negedge clk);
        chk("err_no_valid", n_valid - nv, 0);

        // zero-depth layer
        @(posedge clk); #1;
        start_i = 1'b1; total_od_i = 8'd0; total_id_i = 4'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("zero_done", {30'd0, done_o, busy_o}, 32'b11);
        @(negedge clk);
        chk("zero_idle", {30'd0, done_o, busy_o}, 32'b00);
        chk("zero_no_valid", n_valid - nv, 0);

        // exactly 256: accepted, last request (126,1)
        for (int o = 0; o < 128; o += 2)
            for (int i = 0; i < 2; i++) push(o, i, 1);
        nv = n_valid;
        run_layer(128, 2, 0, "l128x2");
        chk("l128x2_count", n_valid - nv, 128);

        // reset mid-ISSUE after two requests
        push(0, 0, 1); push(0, 1, 1);
        @(posedge clk); #1;
        start_i = 1'b1; total_od_i = 8'd4; total_id_i = 4'd2; pe_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", {19'd0, weight_od1_o, weight_id_o, weight_main_valid_o}, 32'd0);
        chk("rst_mid_flags", {28'd0, weight_od2_valid_o, busy_o, done_o, err_o}, 32'd0);
        chk("rst_mid_sb", sb.size(), 0);
        @(posedge clk); #1 reset = 1'b1;

        // fresh start after reset
        push(0, 0, 1); push(2, 0, 1); push(4, 0, 0);
        run_layer(5, 1, 0, "post_rst");

        // start during ISSUE is ignored
        push(0, 0, 1); push(0, 1, 1); push(2, 0, 1); push(2, 1, 1);
        run_layer(4, 2, 2, "restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
